// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code width and op-code values used by the ALU
// and by every block that drives it.
package alu_pkg;
   localparam int ALU_OP_W = 3;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd0;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'd1;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'd2;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'd3;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 3'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'd5;
endpackage

// File: rtl/alu.sv
// Combinational ALU: add, bitwise logic and signed/unsigned set-less-than.
// Undefined op codes yield zero, which also raises the zero flag.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] eval,
   output logic              zero
);
   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic                     lt_s;
   logic                     lt_u;

   assign a_s  = a;
   assign b_s  = b;
   assign lt_s = a_s < b_s;
   assign lt_u = a < b;

   always_comb begin
      eval = '0;
      case (op)
         OP_W'(ALU_ADD):  eval = a + b;
         OP_W'(ALU_AND):  eval = a & b;
         OP_W'(ALU_OR):   eval = a | b;
         OP_W'(ALU_XOR):  eval = a ^ b;
         OP_W'(ALU_SLT):  eval = {{(DATA_W-1){1'b0}}, lt_s};
         OP_W'(ALU_SLTU): eval = {{(DATA_W-1){1'b0}}, lt_u};
         default:         eval = '0;
      endcase
   end

   assign zero = (eval == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared ALU. The result sits in
// one registered slot until its owner accepts it; a drain and a new accept may
// share a cycle, so back-to-back operations run at one per cycle.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   input  logic [OP_W-1:0]   req_op0,
   input  logic [OP_W-1:0]   req_op1,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_eval,
   output logic              rsp_zero
);
   logic              slot_full;
   logic              slot_owner;
   logic              last_grant;
   logic              any_req;
   logic              grant_sel;
   logic              free;
   logic              accept;
   logic              drain;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_eval;
   logic              alu_zero;

   assign rsp_valid = {slot_full & slot_owner, slot_full & ~slot_owner};
   assign drain     = rsp_valid[slot_owner] & rsp_ready[slot_owner];
   assign free      = ~slot_full | drain;

   // With a lone requester grant_sel follows req_valid[1]; with none it is 0,
   // which also parks the ALU on port 0 operands.
   assign any_req   = |req_valid;
   assign grant_sel = (&req_valid) ? ~last_grant : req_valid[1];

   assign req_ready = (~rst & free & any_req) ? {grant_sel, ~grant_sel} : 2'b00;
   assign accept    = |(req_valid & req_ready);

   assign alu_a  = grant_sel ? req_a1  : req_a0;
   assign alu_b  = grant_sel ? req_b1  : req_b0;
   assign alu_op = grant_sel ? req_op1 : req_op0;

   alu #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .op   (alu_op),
      .eval (alu_eval),
      .zero (alu_zero)
   );

   // Result slot and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full  <= 1'b0;
         slot_owner <= 1'b0;
         last_grant <= 1'b1;
         rsp_eval   <= '0;
         rsp_zero   <= 1'b0;
      end else if (accept) begin
         slot_full  <= 1'b1;
         slot_owner <= grant_sel;
         last_grant <= grant_sel;
         rsp_eval   <= alu_eval;
         rsp_zero   <= alu_zero;
      end else if (drain) begin
         slot_full  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed results into a
// scoreboard that a negedge monitor pops whenever a response is consumed.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DATA_W = 32;

   typedef struct packed {
      logic              port;
      logic [DATA_W-1:0] eval;
      logic              zero;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [2:0]        req_op0, req_op1;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_eval;
   logic              rsp_zero;

   logic [DATA_W-1:0] exp_eval0, exp_eval1;
   logic              exp_zero0, exp_zero1;
   exp_t              sb[$];
   int                total = 0;
   int                bad   = 0;

   alu_arbiter #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_op0   (req_op0),
      .req_op1   (req_op1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_eval  (rsp_eval),
      .rsp_zero  (rsp_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic p0(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                     input logic [2:0] op, input logic [DATA_W-1:0] e, input logic z);
      req_a0 = a; req_b0 = b; req_op0 = op; exp_eval0 = e; exp_zero0 = z;
   endtask

   task automatic p1(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                     input logic [2:0] op, input logic [DATA_W-1:0] e, input logic z);
      req_a1 = a; req_b1 = b; req_op1 = op; exp_eval1 = e; exp_zero1 = z;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Monitor: pop on consumption first, then record this cycle's accepts.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", {31'd0, 1'b1}, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_port", i, {31'd0, e.port});
                  chk("rsp_eval", rsp_eval, e.eval);
                  chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
               end
            end
         end
         if (req_valid[0] && req_ready[0]) sb.push_back('{1'b0, exp_eval0, exp_zero0});
         if (req_valid[1] && req_ready[1]) sb.push_back('{1'b1, exp_eval1, exp_zero1});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      p0('0, '0, ALU_ADD, '0, 1'b1);
      p1('0, '0, ALU_ADD, '0, 1'b1);
      repeat (2) tick();
      req_valid = 2'b01;
      smp();
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      chk("reset_rsp_eval", rsp_eval, 32'd0);
      chk("reset_rsp_zero", rsp_zero, 1'b0);
      chk("reset_req_ready", req_ready, 2'b00);
      tick();

      // single ADD on port 0
      rst = 1'b0; rsp_ready = 2'b11;
      p0(32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0);
      req_valid = 2'b01;
      smp(); chk("single_req_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      smp();
      chk("single_rsp_valid", rsp_valid, 2'b01);
      chk("single_rsp_eval", rsp_eval, 32'd12);
      chk("single_rsp_zero", rsp_zero, 1'b0);
      tick();
      smp(); chk("single_drained", rsp_valid, 2'b00);
      tick();

      // contention right after reset: p0 first, then alternate
      rst = 1'b1; tick(); rst = 1'b0;
      p0(32'hF0, 32'hF0, ALU_XOR, 32'd0, 1'b1);
      p1(32'd1, 32'd2, ALU_SLTU, 32'd1, 1'b0);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         smp();
         chk("rr_req_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
         if (k > 0) chk("rr_rsp_valid", rsp_valid, (k % 2) ? 2'b01 : 2'b10);
         tick();
      end
      req_valid = 2'b00;
      smp(); tick();

      // backpressure: p1 result held three cycles while p0 waits
      rsp_ready = 2'b01;
      p1(32'd3, 32'd4, ALU_ADD, 32'd7, 1'b0);
      req_valid = 2'b10;
      smp(); chk("bp_p1_ready", req_ready, 2'b10);
      tick();
      p0(32'h0F, 32'hF0, ALU_OR, 32'hFF, 1'b0);
      req_valid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("bp_hold_ready", req_ready, 2'b00);
         chk("bp_hold_valid", rsp_valid, 2'b10);
         chk("bp_hold_eval", rsp_eval, 32'd7);
         tick();
      end
      rsp_ready = 2'b11;
      smp(); chk("bp_release_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      smp();
      chk("bp_next_valid", rsp_valid, 2'b01);
      chk("bp_next_eval", rsp_eval, 32'hFF);
      tick();

      // signed vs unsigned compare, back to back
      p0(32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1, 1'b0);
      req_valid = 2'b01;
      smp(); chk("slt_ready", req_ready, 2'b01);
      tick();
      p0(32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0, 1'b1);
      smp();
      chk("sltu_ready", req_ready, 2'b01);
      chk("slt_eval", rsp_eval, 32'd1);
      tick(); req_valid = 2'b00;
      smp();
      chk("sltu_eval", rsp_eval, 32'd0);
      chk("sltu_zero", rsp_zero, 1'b1);
      tick();

      // reset with a held result discards it and restores p0 priority
      rsp_ready = 2'b00;
      p1(32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0);
      req_valid = 2'b10;
      smp(); tick();
      req_valid = 2'b00;
      smp(); chk("mid_full", rsp_valid, 2'b10);
      tick();
      rst = 1'b1; req_valid = 2'b11;
      p0(32'hF0, 32'hF0, ALU_XOR, 32'd0, 1'b1);
      p1(32'd1, 32'd2, ALU_SLTU, 32'd1, 1'b0);
      smp(); chk("rst_req_ready", req_ready, 2'b00);
      tick();
      rst = 1'b0; rsp_ready = 2'b11;
      smp();
      chk("post_rst_valid", rsp_valid, 2'b00);
      chk("post_rst_eval", rsp_eval, 32'd0);
      chk("post_rst_grant", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      smp(); tick();

      // undefined op code
      p1(32'd5, 32'd9, 3'd7, 32'd0, 1'b1);
      req_valid = 2'b10;
      smp(); chk("inv_ready", req_ready, 2'b10);
      tick(); req_valid = 2'b00;
      smp();
      chk("inv_valid", rsp_valid, 2'b10);
      chk("inv_eval", rsp_eval, 32'd0);
      chk("inv_zero", rsp_zero, 1'b1);
      tick();
      repeat (2) tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
